// File: rtl/maze_generator_param.sv
// Perfect-maze generator (sidewinder / binary tree) into a 1-bit tile RAM.
// The RAM is cleared, row 0 is opened, then one tile is carved per clock from an LFSR.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start, no maze held
// CLEAR | raster pass: floor on even/even cells, wall elsewhere
// ROW0  | open the odd tiles of row 0 into a corridor
// CARVE | one cell per clock on rows 2,4,..; LFSR steps each cycle
// DONE  | maze complete and readable; start regenerates
module maze_generator_param #(
   parameter int                MAZE_W    = 31,
   parameter int                MAZE_H    = 41,
   parameter int                LFSR_W    = 11,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = 11'h500,
   parameter int                ADDR_W    = $clog2(MAZE_W*MAZE_H)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [LFSR_W-1:0] seed,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_data,
   output logic              busy,
   output logic              done
);

   localparam int N  = MAZE_W * MAZE_H;
   localparam int XW = $clog2(MAZE_W);
   localparam int YW = $clog2(MAZE_H);
   localparam logic [XW-1:0]   X_LAST  = XW'(MAZE_W - 1);
   localparam logic [XW-1:0]   X_R0END = XW'(MAZE_W - 2);
   localparam logic [YW-1:0]   Y_LAST  = YW'(MAZE_H - 1);
   localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(MAZE_W);
   localparam logic [ADDR_W:0]   N_EXT = (ADDR_W+1)'(N);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ROW0, S_CARVE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                start_q, start_d;
   logic                mode_q, mode_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [XW-1:0]       x_q, x_d;
   logic [YW-1:0]       y_q, y_d;
   logic [XW-1:0]       cand_q, cand_d;
   logic                open_q, open_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                rd_data_q, rd_data_d;

   logic                wr_en;
   logic                wr_data;
   logic [XW-1:0]       wr_x;
   logic [YW-1:0]       wr_y;
   logic [ADDR_W-1:0]   wr_addr;
   logic                close;
   logic [XW-1:0]       cand_eff;
   logic                rd_oob;

   logic                ram_q [0:N-1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start_q) state_d = S_CLEAR;
         S_CLEAR:        if (x_q == X_LAST && y_q == Y_LAST) state_d = S_ROW0;
         S_ROW0:         if (x_q == X_R0END) state_d = S_CARVE;
         S_CARVE:        if (x_q == X_LAST && y_q == Y_LAST) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      start_d  = start && !start_q && (state_q == S_IDLE || state_q == S_DONE);
      mode_d   = mode_q;
      lfsr_d   = lfsr_q;
      x_d      = x_q;
      y_d      = y_q;
      cand_d   = cand_q;
      open_d   = open_q;
      wr_en    = 1'b0;
      wr_data  = 1'b1;
      wr_x     = x_q;
      wr_y     = y_q;
      close    = 1'b0;
      cand_eff = cand_q;
      if (start_d) begin
         mode_d = mode;
         lfsr_d = (seed == '0) ? '1 : seed;
      end
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_q) begin
               x_d = '0;
               y_d = '0;
            end
         end
         S_CLEAR: begin
            wr_en   = 1'b1;
            wr_data = x_q[0] | y_q[0];
            if (x_q == X_LAST) begin
               x_d = '0;
               y_d = y_q + YW'(1);
               if (y_q == Y_LAST) begin
                  x_d = XW'(1);
                  y_d = '0;
               end
            end else begin
               x_d = x_q + XW'(1);
            end
         end
         S_ROW0: begin
            wr_en   = 1'b1;
            wr_data = 1'b0;
            wr_y    = '0;
            x_d     = x_q + XW'(2);
            if (x_q == X_R0END) begin
               x_d    = '0;
               y_d    = YW'(2);
               open_d = 1'b0;
            end
         end
         S_CARVE: begin
            wr_en   = 1'b1;
            wr_data = 1'b0;
            lfsr_d  = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
            close   = (x_q == X_LAST) || lfsr_q[0];
            if (mode_q) begin
               if (close) wr_y = y_q - YW'(1);
               else       wr_x = x_q + XW'(1);
            end else begin
               // a closing cell uses the candidate chosen on this same cell
               cand_eff = (!open_q || lfsr_q[1]) ? x_q : cand_q;
               cand_d   = cand_eff;
               open_d   = !close;
               if (close) begin
                  wr_x = cand_eff;
                  wr_y = y_q - YW'(1);
               end else begin
                  wr_x = x_q + XW'(1);
               end
            end
            if (x_q == X_LAST) begin
               x_d = '0;
               y_d = y_q + YW'(2);
            end else begin
               x_d = x_q + XW'(2);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy_d  = (state_d == S_CLEAR) || (state_d == S_ROW0) || (state_d == S_CARVE);
      done_d  = (state_d == S_DONE);
      wr_addr = ADDR_W'(wr_y) * W_A + ADDR_W'(wr_x);
      rd_oob  = ({1'b0, rd_addr} >= N_EXT);
      // also held high on the final carve edge so a read never sees a half-built maze
      rd_data_d = (busy_q || busy_d || rd_oob) ? 1'b1 : ram_q[rd_addr];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         start_q   <= 1'b0;
         mode_q    <= 1'b0;
         lfsr_q    <= '1;
         x_q       <= '0;
         y_q       <= '0;
         cand_q    <= '0;
         open_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_data_q <= 1'b1;
      end else begin
         start_q   <= start_d;
         mode_q    <= mode_d;
         lfsr_q    <= lfsr_d;
         x_q       <= x_d;
         y_q       <= y_d;
         cand_q    <= cand_d;
         open_q    <= open_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) ram_q[wr_addr] <= wr_data;
   end

   assign rd_data = rd_data_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
